// File: rtl/bus_readback_if.sv
// ============================================================================
// Module      : bus_readback_if
// Description : 6502-side GPU register bus (strobe, direction, register
//               select, write data, read data and driver enable).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bus_readback_if;
  logic       cs_clock;   // active-low chip select / strobe, asynchronous
  logic       rw;         // 1 = CPU read, 0 = CPU write
  logic [2:0] addr;       // register select
  logic [7:0] data_in;    // CPU write data
  logic [7:0] data_out;   // read data back to the CPU
  logic       data_oe;    // bus driver enable

  // CPU side drives the strobe, select and write data
  modport master (
    output cs_clock, rw, addr, data_in,
    input  data_out, data_oe
  );

  // GPU side samples the bus and returns read data
  modport slave (
    input  cs_clock, rw, addr, data_in,
    output data_out, data_oe
  );
endinterface

`default_nettype wire

// File: rtl/bus_readback.sv
// ============================================================================
// Module      : bus_readback
// Description : CPU read path of the GPU. Tracks the shared VRAM pointer,
//               prefetches the addressed tile/attribute/color byte into a
//               read buffer, returns it on register 6 reads and then
//               auto-increments the pointer and prefetches again.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_readback #(
  parameter logic [15:0] ATTR_BASE  = 16'h0800,
  parameter logic [15:0] COLOR_BASE = 16'h1800,
  parameter logic [15:0] COLOR_END  = 16'h1810,
  parameter logic [15:0] INCREMENT  = 16'd1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  bus_readback_if.slave    bus,
  input  wire logic        mem_grant,
  output logic             tile_memory_read_enable,
  output logic [10:0]      tile_memory_read_addr,
  input  wire logic [7:0]  tile_memory_read_data,
  output logic             attribute_memory_read_enable,
  output logic [11:0]      attribute_memory_read_addr,
  input  wire logic [7:0]  attribute_memory_read_data,
  output logic             color_memory_read_enable,
  output logic [3:0]       color_memory_read_addr,
  input  wire logic [7:0]  color_memory_read_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQUEST = 2'd1, CAPTURE = 2'd2} state_t;
  typedef enum logic [1:0] {REG_NONE = 2'd0, REG_TILE = 2'd1, REG_ATTR = 2'd2, REG_COLOR = 2'd3} region_t;

  // Bus synchronizers; cs_prev_q holds the previous synchronized strobe level
  logic [1:0] cs_sync_q;
  logic       cs_prev_q;
  logic [1:0] rw_sync_q;
  logic [2:0] addr_s1_q, addr_s2_q;
  logic [7:0] data_s1_q, data_s2_q;

  logic [15:0] pointer_q, pointer_d;
  logic        trig_q, trig_d;
  logic        restart_q;
  logic [7:0]  buffer_q;
  state_t      state_q;
  region_t     region_q;
  logic [10:0] tile_addr_q;
  logic [11:0] attr_addr_q;
  logic [3:0]  color_addr_q;

  logic        strobe;
  region_t     region_d;
  logic [11:0] attr_off;
  logic [3:0]  color_off;
  logic        busy;

  assign strobe = cs_sync_q[1] & ~cs_prev_q;

  // Two-stage synchronization of every bus input; strobe idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q <= 2'b11;
      cs_prev_q <= 1'b1;
      rw_sync_q <= 2'b00;
      addr_s1_q <= 3'd0;
      addr_s2_q <= 3'd0;
      data_s1_q <= 8'd0;
      data_s2_q <= 8'd0;
    end else begin
      cs_sync_q <= {cs_sync_q[0], bus.cs_clock};
      cs_prev_q <= cs_sync_q[1];
      rw_sync_q <= {rw_sync_q[0], bus.rw};
      addr_s1_q <= bus.addr;
      addr_s2_q <= addr_s1_q;
      data_s1_q <= bus.data_in;
      data_s2_q <= data_s1_q;
    end
  end

  // Pointer updates and fetch triggers decoded from a completed strobe
  always_comb begin
    pointer_d = pointer_q;
    trig_d    = 1'b0;
    if (strobe) begin
      if (rw_sync_q[1]) begin
        if (addr_s2_q == 3'd6) begin
          pointer_d = pointer_q + INCREMENT;
          trig_d    = 1'b1;
        end
      end else begin
        case (addr_s2_q)
          3'd4: begin pointer_d[7:0]  = data_s2_q; trig_d = 1'b1; end
          3'd5: begin pointer_d[15:8] = data_s2_q; trig_d = 1'b1; end
          3'd6: trig_d = 1'b1;
          default: trig_d = 1'b0;
        endcase
      end
    end
  end

  // Pointer register and one-cycle trigger pulse (always consumed next cycle)
  always_ff @(posedge clk) begin
    if (reset) begin
      pointer_q <= 16'd0;
      trig_q    <= 1'b0;
    end else begin
      pointer_q <= pointer_d;
      trig_q    <= trig_d;
    end
  end

  // Region decode of the live pointer; offsets are truncated to port width
  always_comb begin
    region_d = REG_NONE;
    if (pointer_q < ATTR_BASE)       region_d = REG_TILE;
    else if (pointer_q < COLOR_BASE) region_d = REG_ATTR;
    else if (pointer_q < COLOR_END)  region_d = REG_COLOR;
  end
  assign attr_off  = pointer_q[11:0] - ATTR_BASE[11:0];
  assign color_off = pointer_q[3:0]  - COLOR_BASE[3:0];

  // Fetch FSM: decode, wait for the shared read port, capture the byte
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      restart_q    <= 1'b0;
      buffer_q     <= 8'd0;
      region_q     <= REG_NONE;
      tile_addr_q  <= 11'd0;
      attr_addr_q  <= 12'd0;
      color_addr_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_q) begin
            if (region_d == REG_NONE) begin
              buffer_q <= 8'd0;
            end else begin
              state_q      <= REQUEST;
              region_q     <= region_d;
              tile_addr_q  <= pointer_q[10:0];
              attr_addr_q  <= attr_off;
              color_addr_q <= color_off;
            end
          end
        end
        REQUEST: begin
          if (trig_q)    restart_q <= 1'b1;
          if (mem_grant) state_q   <= CAPTURE;
        end
        CAPTURE: begin
          if (restart_q || trig_q) begin
            // Sample is stale: re-decode from the latest pointer. A pointer
            // that moved into unmapped space resolves immediately to 0.
            restart_q <= 1'b0;
            if (region_d == REG_NONE) begin
              buffer_q <= 8'd0;
              state_q  <= IDLE;
            end else begin
              state_q      <= REQUEST;
              region_q     <= region_d;
              tile_addr_q  <= pointer_q[10:0];
              attr_addr_q  <= attr_off;
              color_addr_q <= color_off;
            end
          end else begin
            case (region_q)
              REG_TILE:  buffer_q <= tile_memory_read_data;
              REG_ATTR:  buffer_q <= attribute_memory_read_data;
              REG_COLOR: buffer_q <= color_memory_read_data;
              default:   buffer_q <= 8'd0;
            endcase
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read enables fire only in the granted REQUEST cycle so the renderer
  // never sees a collision; addresses are held in registers
  assign tile_memory_read_enable      = (state_q == REQUEST) & mem_grant & (region_q == REG_TILE);
  assign attribute_memory_read_enable = (state_q == REQUEST) & mem_grant & (region_q == REG_ATTR);
  assign color_memory_read_enable     = (state_q == REQUEST) & mem_grant & (region_q == REG_COLOR);
  assign tile_memory_read_addr        = tile_addr_q;
  assign attribute_memory_read_addr   = attr_addr_q;
  assign color_memory_read_addr       = color_addr_q;

  assign busy = (state_q != IDLE) | trig_q;

  // Bus read mux and driver enable work from the raw bus signals
  always_comb begin
    bus.data_oe  = bus.rw & ~bus.cs_clock & (bus.addr >= 3'd4);
    bus.data_out = 8'h00;
    case (bus.addr)
      3'd4:    bus.data_out = pointer_q[7:0];
      3'd5:    bus.data_out = pointer_q[15:8];
      3'd6:    bus.data_out = buffer_q;
      3'd7:    bus.data_out = {7'd0, busy};
      default: bus.data_out = 8'h00;
    endcase
  end

endmodule

`default_nettype wire
